seq_arith_unit: RTL and testbench

SEQ_ARITH_UNIT -- requirements
Module: seq_arith_unit

---
 rtl/seq_arith_pkg.sv | 21 ++
 rtl/seq_arith_div.sv | 67 ++++++
 rtl/seq_arith_unit.sv | 172 +++++++++++++++++
 tb/tb_seq_arith_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/seq_arith_pkg.sv
// Shared types for the sequential arithmetic unit: opcode encoding and control FSM states.
package seq_arith_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_MOD = 3'd4,
    OP_INC = 3'd5,
    OP_DEC = 3'd6,
    OP_RSV = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_arith_div.sv
// Restoring unsigned divider: one quotient bit per cycle, WIDTH cycles after i_start.
// o_done marks the edge that completes the run; o_quotient/o_remainder are valid on that edge.
module seq_arith_div #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dsr;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_fit;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_rem_next;

  // Partial remainder stays below the divisor, so a non-negative trial never sets bit WIDTH.
  always_comb begin
    w_shift    = {r_rem, r_quo[WIDTH-1]};
    w_trial    = w_shift - {1'b0, r_dsr};
    w_fit      = ~w_trial[WIDTH];
    w_rem_next = w_fit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    w_quo_next = {r_quo[WIDTH-2:0], w_fit};
  end

  assign o_done      = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
  assign o_quotient  = w_quo_next;
  assign o_remainder = w_rem_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_dsr  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_quo  <= i_dividend;
      r_rem  <= '0;
      r_dsr  <= i_divisor;
    end else if (r_busy) begin
      r_quo <= w_quo_next;
      r_rem <= w_rem_next;
      if (o_done) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_arith_unit.sv
// Sequential arithmetic unit: single-cycle ADD/SUB/INC/DEC, WIDTH-cycle shift-add MUL,
// and optional restoring DIV/MOD enabled by the SEQ_ARITH_DIV_EN macro.
module seq_arith_unit
  import seq_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               div_zero,
  output logic               illegal
);

  state_e             r_state;
  op_e                r_op;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_result;
  logic               r_out_valid;
  logic               r_div_zero;
  logic               r_illegal;

  op_e                w_op;
  logic               w_accept;
  logic               w_last;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_imm_result;
  logic               w_imm_dz;
  logic               w_imm_ill;
  logic               w_go_busy;

  assign w_op       = op_e'(op);
  assign w_accept   = in_valid && (r_state == ST_IDLE);
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_comb begin
    w_imm_result = '0;
    w_imm_dz     = 1'b0;
    w_imm_ill    = 1'b0;
    w_go_busy    = 1'b0;
    case (w_op)
      OP_ADD: w_imm_result[WIDTH:0] = {1'b0, a} + {1'b0, b};
      OP_SUB: w_imm_result[WIDTH:0] = {1'b0, a} - {1'b0, b};
      OP_INC: w_imm_result[WIDTH-1:0] = a + WIDTH'(1);
      OP_DEC: w_imm_result[WIDTH-1:0] = a - WIDTH'(1);
      OP_MUL: w_go_busy = 1'b1;
      OP_DIV, OP_MOD: begin
`ifdef SEQ_ARITH_DIV_EN
        if (b == '0) begin
          w_imm_dz = 1'b1;
          w_imm_result[WIDTH-1:0] = (w_op == OP_DIV) ? {WIDTH{1'b1}} : a;
        end else begin
          w_go_busy = 1'b1;
        end
`else
        w_imm_ill = 1'b1;
`endif
      end
      default: w_imm_ill = 1'b1;
    endcase
  end

`ifdef SEQ_ARITH_DIV_EN
  logic             w_div_start;
  logic             w_div_done;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  assign w_div_start = w_accept && w_go_busy && (w_op != OP_MUL);

  seq_arith_div #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_div_start),
    .i_dividend  (a),
    .i_divisor   (b),
    .o_done      (w_div_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_ADD;
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_acc       <= '0;
      r_mplier    <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_div_zero  <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op <= w_op;
            if (w_go_busy) begin
              r_state  <= ST_BUSY;
              r_cnt    <= '0;
              r_acc    <= '0;
              r_mcand  <= {{WIDTH{1'b0}}, a};
              r_mplier <= b;
            end else begin
              r_state     <= ST_DONE;
              r_result    <= w_imm_result;
              r_div_zero  <= w_imm_dz;
              r_illegal   <= w_imm_ill;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (r_op == OP_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (w_last) begin
              r_state     <= ST_DONE;
              r_cnt       <= '0;
              r_result    <= w_acc_next;
              r_out_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
`ifdef SEQ_ARITH_DIV_EN
          else if (w_div_done) begin
            r_state     <= ST_DONE;
            r_result    <= {{WIDTH{1'b0}}, (r_op == OP_DIV) ? w_quo : w_rem};
            r_out_valid <= 1'b1;
          end
`endif
        end
        ST_DONE: begin
          // Flags are meaningful only alongside out_valid, so drop them at the handshake.
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_div_zero  <= 1'b0;
            r_illegal   <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign div_zero  = r_div_zero;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed vector bench for seq_arith_unit at WIDTH=8; expectations follow SEQ_ARITH_DIV_EN.
module tb_seq_arith_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        div_zero;
  logic        illegal;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        dz;
    logic        ill;
    int          lat;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  seq_arith_unit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .div_zero  (div_zero),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request from IDLE with out_ready=1 and check latency, busy, result, flags.
  task automatic do_op(input string tag, input vec_t v);
    int   lat;
    logic saw_ready;
    op = v.op; a = v.a; b = v.b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'd0; a = 8'hA5; b = 8'h5A;
    lat = 0;
    saw_ready = 1'b0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (in_ready) saw_ready = 1'b1;
      if (div_zero || illegal) saw_ready = 1'b1;
    end
    chk({tag, " latency"}, 64'(lat), 64'(v.lat));
    chk({tag, " ready_or_flag_while_busy"}, 64'(saw_ready), 64'd0);
    chk({tag, " result"}, 64'(result), 64'(v.res));
    chk({tag, " div_zero"}, 64'(div_zero), 64'(v.dz));
    chk({tag, " illegal"}, 64'(illegal), 64'(v.ill));
    $display("op=%0d a=%0d b=%0d -> result=%04h dz=%0b ill=%0b lat=%0d", v.op, v.a, v.b, result, div_zero, illegal, lat);
    @(posedge clk); #1;
    chk({tag, " out_valid_after_hs"}, 64'(out_valid), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{3'd0, 8'd200, 8'd100, 16'h012C, 1'b0, 1'b0, 1};
    vecs[1]  = '{3'd1, 8'd5,   8'd10,  16'h01FB, 1'b0, 1'b0, 1};
    vecs[2]  = '{3'd6, 8'd0,   8'd33,  16'h00FF, 1'b0, 1'b0, 1};
    vecs[3]  = '{3'd5, 8'd255, 8'd33,  16'h0000, 1'b0, 1'b0, 1};
    vecs[4]  = '{3'd2, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0, 9};
    vecs[5]  = '{3'd2, 8'd13,  8'd11,  16'd143,  1'b0, 1'b0, 9};
    vecs[6]  = '{3'd2, 8'd0,   8'd77,  16'd0,    1'b0, 1'b0, 9};
    vecs[7]  = '{3'd0, 8'd255, 8'd255, 16'h01FE, 1'b0, 1'b0, 1};
    vecs[8]  = '{3'd1, 8'd10,  8'd5,   16'd5,    1'b0, 1'b0, 1};
    vecs[9]  = '{3'd7, 8'd3,   8'd4,   16'd0,    1'b0, 1'b1, 1};
`ifdef SEQ_ARITH_DIV_EN
    vecs[10] = '{3'd3, 8'd100, 8'd7,   16'd14,   1'b0, 1'b0, 9};
    vecs[11] = '{3'd4, 8'd100, 8'd7,   16'd2,    1'b0, 1'b0, 9};
    vecs[12] = '{3'd3, 8'd9,   8'd0,   16'h00FF, 1'b1, 1'b0, 1};
    vecs[13] = '{3'd4, 8'd9,   8'd0,   16'd9,    1'b1, 1'b0, 1};
    vecs[14] = '{3'd3, 8'd255, 8'd1,   16'd255,  1'b0, 1'b0, 9};
    vecs[15] = '{3'd4, 8'd7,   8'd200, 16'd7,    1'b0, 1'b0, 9};
`else
    vecs[10] = '{3'd3, 8'd100, 8'd7,   16'd0,    1'b0, 1'b1, 1};
    vecs[11] = '{3'd4, 8'd100, 8'd7,   16'd0,    1'b0, 1'b1, 1};
    vecs[12] = '{3'd3, 8'd9,   8'd0,   16'd0,    1'b0, 1'b1, 1};
    vecs[13] = '{3'd4, 8'd9,   8'd0,   16'd0,    1'b0, 1'b1, 1};
    vecs[14] = '{3'd3, 8'd255, 8'd1,   16'd0,    1'b0, 1'b1, 1};
    vecs[15] = '{3'd4, 8'd7,   8'd200, 16'd0,    1'b0, 1'b1, 1};
`endif

    // Reset state
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; a = 8'd0; b = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    chk("reset div_zero", 64'(div_zero), 64'd0);
    chk("reset illegal", 64'(illegal), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    $display("reset: in_ready=%0b out_valid=%0b result=%04h", in_ready, out_valid, result);

    for (int i = 0; i < NVEC; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Stall in DONE for 5 cycles while a competing request is offered
    op = 3'd0; a = 8'd3; b = 8'd4; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    op = 3'd0; a = 8'd100; b = 8'd100;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d out_valid", c), 64'(out_valid), 64'd1);
      chk($sformatf("stall%0d result", c), 64'(result), 64'd7);
      chk($sformatf("stall%0d in_ready", c), 64'(in_ready), 64'd0);
    end
    $display("stall: result=%04h held for 5 cycles", result);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall handshake out_valid", 64'(out_valid), 64'd0);
    chk("stall handshake in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("stall no second accept", 64'(out_valid), 64'd0);

    // Reset in the middle of a multiply
    op = 3'd2; a = 8'd255; b = 8'd255; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mul_abort busy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mul_abort in_ready", 64'(in_ready), 64'd1);
    chk("mul_abort out_valid", 64'(out_valid), 64'd0);
    repeat (10) @(negedge clk);
    chk("mul_abort discarded", 64'(out_valid), 64'd0);
    $display("abort: in_ready=%0b out_valid=%0b after mid-MUL reset", in_ready, out_valid);
    v = '{3'd0, 8'd1, 8'd1, 16'd2, 1'b0, 1'b0, 1};
    do_op("post_abort_add", v);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
